// File: rtl/mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// mem_access_ctrl
//
// MEM-stage data-memory controller. Takes the EX/MEM pipeline register outputs,
// runs one request/ready transaction per load or store, places store bytes on
// the correct lanes, and sign/zero-extends load data. MemStall holds EX/MEM and
// the earlier stages until the access reaches DONE.
//
// Optional feature: define DMEM_TIMEOUT_EN to bound the ready wait to
// TIMEOUT_CYCLES REQ cycles. An expired wait ends the access with a one-cycle
// MemBusError pulse and a zero load result. Without the macro there is no
// counter, REQ waits indefinitely and MemBusError is tied low.
//
// Ports
//   clk, rst_n           pipeline clock (rising edge), async active-low reset
//   EXMEMALUResult       byte address of the access
//   EXMEMMemWriteData    right-justified store data
//   EXMEMMemRead/RBits   load request / load type (lw, lh, lhu, lb, lbu)
//   EXMEMMemWrite/WrBits store request / store width (word, half, byte)
//   ExtStall             another stall source is holding EX/MEM
//   dmem_*               data-memory bus (req/we/addr/wdata/be out, rdata/ready in)
//   MemStall             hold EX/MEM and earlier pipeline registers
//   MemReadData          registered, extended load result
//   MemMisalign          one-cycle misaligned-access pulse
//   MemBusError          one-cycle timeout pulse
// -----------------------------------------------------------------------------
module mem_access_ctrl #(
   parameter int unsigned TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic [31:0] EXMEMALUResult,
   input  logic [31:0] EXMEMMemWriteData,
   input  logic        EXMEMMemRead,
   input  logic [2:0]  EXMEMMemRBits,
   input  logic        EXMEMMemWrite,
   input  logic [1:0]  EXMEMMemWrBits,
   input  logic        ExtStall,
   output logic        dmem_req,
   output logic        dmem_we,
   output logic [31:0] dmem_addr,
   output logic [31:0] dmem_wdata,
   output logic [3:0]  dmem_be,
   input  logic [31:0] dmem_rdata,
   input  logic        dmem_ready,
   output logic        MemStall,
   output logic [31:0] MemReadData,
   output logic        MemMisalign,
   output logic        MemBusError
);

   typedef enum logic [1:0] {IDLE, REQ, DONE} state_t;
   typedef enum logic [1:0] {SZ_BYTE, SZ_HALF, SZ_WORD} size_t;

   // Load-type codes; anything else behaves as lw.
   localparam logic [2:0] LD_LH  = 3'b001;
   localparam logic [2:0] LD_LHU = 3'b010;
   localparam logic [2:0] LD_LB  = 3'b011;
   localparam logic [2:0] LD_LBU = 3'b100;

   state_t      state_q, state_d;
   logic        dmem_req_q, dmem_req_d;
   logic        dmem_we_q, dmem_we_d;
   logic [31:0] dmem_addr_q, dmem_addr_d;
   logic [31:0] dmem_wdata_q, dmem_wdata_d;
   logic [3:0]  dmem_be_q, dmem_be_d;
   logic [1:0]  lane_q, lane_d;          // addr[1:0] of the access in flight
   logic [2:0]  ld_type_q, ld_type_d;    // load type of the access in flight
   logic [31:0] read_data_q, read_data_d;
   logic        misalign_q, misalign_d;

`ifdef DMEM_TIMEOUT_EN
   localparam int unsigned CNT_W = ($clog2(TIMEOUT_CYCLES + 1) > 8) ?
                                   $clog2(TIMEOUT_CYCLES + 1) : 8;
   // Last count value before the limit: a REQ cycle that starts here and sees
   // no ready is the final one allowed.
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             bus_err_q, bus_err_d;
`endif

   // ---------------------------------------------------------------------------
   // Access decode
   // ---------------------------------------------------------------------------
   logic  pending;
   logic  is_store;
   size_t acc_size;
   logic  misaligned;
   logic [3:0]  store_be;
   logic [31:0] store_wdata;

   assign pending  = EXMEMMemRead | EXMEMMemWrite;
   assign is_store = EXMEMMemWrite;   // a store wins when both are set

   always_comb begin
      // NOTE: every signal assigned in always_comb gets a default first so no
      // path leaves it unassigned, which would infer a latch.
      acc_size = SZ_WORD;
      if (is_store) begin
         unique case (EXMEMMemWrBits)
            2'b01:   acc_size = SZ_HALF;
            2'b10:   acc_size = SZ_BYTE;
            default: acc_size = SZ_WORD;
         endcase
      end else begin
         unique case (EXMEMMemRBits)
            LD_LH, LD_LHU: acc_size = SZ_HALF;
            LD_LB, LD_LBU: acc_size = SZ_BYTE;
            default:       acc_size = SZ_WORD;
         endcase
      end
   end

   assign misaligned = ((acc_size == SZ_HALF) && EXMEMALUResult[0]) ||
                       ((acc_size == SZ_WORD) && (EXMEMALUResult[1:0] != 2'b00));

   always_comb begin
      store_be    = 4'b1111;
      store_wdata = 32'h0;
      if (is_store) begin
         unique case (acc_size)
            SZ_BYTE: begin
               store_be    = 4'b0001 << EXMEMALUResult[1:0];
               store_wdata = {4{EXMEMMemWriteData[7:0]}};
            end
            SZ_HALF: begin
               store_be    = EXMEMALUResult[1] ? 4'b1100 : 4'b0011;
               store_wdata = {2{EXMEMMemWriteData[15:0]}};
            end
            default: begin
               store_be    = 4'b1111;
               store_wdata = EXMEMMemWriteData;
            end
         endcase
      end
   end

   // Pick the addressed lane out of the read word and extend it.
   function automatic logic [31:0] extend_load(input logic [31:0] rdata,
                                               input logic [1:0]  lane,
                                               input logic [2:0]  ld_type);
      logic [7:0]  b;
      logic [15:0] h;
      b = rdata[{lane, 3'b000} +: 8];
      h = lane[1] ? rdata[31:16] : rdata[15:0];
      unique case (ld_type)
         LD_LH:   return {{16{h[15]}}, h};
         LD_LHU:  return {16'h0, h};
         LD_LB:   return {{24{b[7]}}, b};
         LD_LBU:  return {24'h0, b};
         default: return rdata;
      endcase
   endfunction

   // ---------------------------------------------------------------------------
   // Next-state logic
   // ---------------------------------------------------------------------------
   always_comb begin
      state_d      = state_q;
      dmem_req_d   = dmem_req_q;
      dmem_we_d    = dmem_we_q;
      dmem_addr_d  = dmem_addr_q;
      dmem_wdata_d = dmem_wdata_q;
      dmem_be_d    = dmem_be_q;
      lane_d       = lane_q;
      ld_type_d    = ld_type_q;
      read_data_d  = read_data_q;
      misalign_d   = 1'b0;   // pulses last exactly one DONE cycle
`ifdef DMEM_TIMEOUT_EN
      cnt_d        = cnt_q;
      bus_err_d    = 1'b0;
`endif

      unique case (state_q)
         IDLE: begin
            if (pending) begin
               if (misaligned) begin
                  // Skip the bus entirely and report in the DONE cycle.
                  state_d     = DONE;
                  misalign_d  = 1'b1;
                  read_data_d = 32'h0;
               end else begin
                  state_d      = REQ;
                  dmem_req_d   = 1'b1;
                  dmem_we_d    = is_store;
                  dmem_addr_d  = {EXMEMALUResult[31:2], 2'b00};
                  dmem_be_d    = store_be;
                  dmem_wdata_d = store_wdata;
                  lane_d       = EXMEMALUResult[1:0];
                  ld_type_d    = EXMEMMemRBits;
`ifdef DMEM_TIMEOUT_EN
                  cnt_d        = '0;
`endif
               end
            end
         end

         REQ: begin
            // Ready is checked first so it wins over a same-cycle timeout.
            if (dmem_ready) begin
               state_d    = DONE;
               dmem_req_d = 1'b0;
               if (!dmem_we_q) begin
                  read_data_d = extend_load(dmem_rdata, lane_q, ld_type_q);
               end
            end
`ifdef DMEM_TIMEOUT_EN
            else if (cnt_q == CNT_LAST) begin
               state_d     = DONE;
               dmem_req_d  = 1'b0;
               read_data_d = 32'h0;
               bus_err_d   = 1'b1;
            end else begin
               cnt_d = cnt_q + 1'b1;
            end
`endif
         end

         DONE: begin
            // EX/MEM advances at the end of this cycle unless ExtStall holds it;
            // either way the instruction now in MEM is never re-issued.
            if (!ExtStall) begin
               state_d = IDLE;
            end
         end

         default: state_d = IDLE;
      endcase
   end

   // ---------------------------------------------------------------------------
   // State registers
   // ---------------------------------------------------------------------------
   // NOTE: sequential state uses non-blocking assignments so every flop samples
   // the pre-edge values; asynchronous reset drops an in-flight request at once.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q      <= IDLE;
         dmem_req_q   <= 1'b0;
         dmem_we_q    <= 1'b0;
         dmem_addr_q  <= 32'h0;
         dmem_wdata_q <= 32'h0;
         dmem_be_q    <= 4'h0;
         lane_q       <= 2'b00;
         ld_type_q    <= 3'b000;
         read_data_q  <= 32'h0;
         misalign_q   <= 1'b0;
`ifdef DMEM_TIMEOUT_EN
         cnt_q        <= '0;
         bus_err_q    <= 1'b0;
`endif
      end else begin
         state_q      <= state_d;
         dmem_req_q   <= dmem_req_d;
         dmem_we_q    <= dmem_we_d;
         dmem_addr_q  <= dmem_addr_d;
         dmem_wdata_q <= dmem_wdata_d;
         dmem_be_q    <= dmem_be_d;
         lane_q       <= lane_d;
         ld_type_q    <= ld_type_d;
         read_data_q  <= read_data_d;
         misalign_q   <= misalign_d;
`ifdef DMEM_TIMEOUT_EN
         cnt_q        <= cnt_d;
         bus_err_q    <= bus_err_d;
`endif
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign dmem_req    = dmem_req_q;
   assign dmem_we     = dmem_we_q;
   assign dmem_addr   = dmem_addr_q;
   assign dmem_wdata  = dmem_wdata_q;
   assign dmem_be     = dmem_be_q;
   assign MemReadData = read_data_q;
   assign MemMisalign = misalign_q;

   // Stall is combinational so the access is held in the very cycle it appears.
   assign MemStall = ((state_q == IDLE) && pending) || (state_q == REQ);

`ifdef DMEM_TIMEOUT_EN
   assign MemBusError = bus_err_q;
`else
   assign MemBusError = 1'b0;
`endif

endmodule

// File: tb/tb_mem_access_ctrl.sv
// -----------------------------------------------------------------------------
// tb_mem_access_ctrl
//
// Directed bench for mem_access_ctrl. Inputs change 1 ns after each rising edge;
// registered outputs are checked there, combinational MemStall after inputs
// settle. Expected values are hand-computed constants.
// -----------------------------------------------------------------------------
module tb_mem_access_ctrl;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [31:0] EXMEMALUResult;
   logic [31:0] EXMEMMemWriteData;
   logic        EXMEMMemRead;
   logic [2:0]  EXMEMMemRBits;
   logic        EXMEMMemWrite;
   logic [1:0]  EXMEMMemWrBits;
   logic        ExtStall;
   logic        dmem_req;
   logic        dmem_we;
   logic [31:0] dmem_addr;
   logic [31:0] dmem_wdata;
   logic [3:0]  dmem_be;
   logic [31:0] dmem_rdata;
   logic        dmem_ready;
   logic        MemStall;
   logic [31:0] MemReadData;
   logic        MemMisalign;
   logic        MemBusError;

   int tests = 0;
   int fails = 0;

   always #5 clk = ~clk;

   mem_access_ctrl #(.TIMEOUT_CYCLES(4)) dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .EXMEMALUResult    (EXMEMALUResult),
      .EXMEMMemWriteData (EXMEMMemWriteData),
      .EXMEMMemRead      (EXMEMMemRead),
      .EXMEMMemRBits     (EXMEMMemRBits),
      .EXMEMMemWrite     (EXMEMMemWrite),
      .EXMEMMemWrBits    (EXMEMMemWrBits),
      .ExtStall          (ExtStall),
      .dmem_req          (dmem_req),
      .dmem_we           (dmem_we),
      .dmem_addr         (dmem_addr),
      .dmem_wdata        (dmem_wdata),
      .dmem_be           (dmem_be),
      .dmem_rdata        (dmem_rdata),
      .dmem_ready        (dmem_ready),
      .MemStall          (MemStall),
      .MemReadData       (MemReadData),
      .MemMisalign       (MemMisalign),
      .MemBusError       (MemBusError)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Pipeline bubble in EX/MEM, bus quiet.
   task automatic idle_bus();
      EXMEMMemRead      = 1'b0;
      EXMEMMemWrite     = 1'b0;
      EXMEMMemRBits     = 3'b000;
      EXMEMMemWrBits    = 2'b00;
      EXMEMALUResult    = 32'h0;
      EXMEMMemWriteData = 32'h0;
      dmem_ready        = 1'b0;
      dmem_rdata        = 32'h0;
   endtask

   // Aligned load completing on the first REQ cycle.
   task automatic do_load(input string tag, input logic [31:0] addr, input logic [2:0] rb,
                          input logic [31:0] rdata, input logic [31:0] exp_data);
      EXMEMMemRead   = 1'b1;
      EXMEMMemRBits  = rb;
      EXMEMALUResult = addr;
      #1;
      check({tag, " idle stall"}, MemStall, 1'b1);
      tick();
      check({tag, " req"}, dmem_req, 1'b1);
      check({tag, " we"}, dmem_we, 1'b0);
      check({tag, " be"}, dmem_be, 4'b1111);
      check({tag, " addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
      check({tag, " req stall"}, MemStall, 1'b1);
      dmem_ready = 1'b1;
      dmem_rdata = rdata;
      tick();
      check({tag, " data"}, MemReadData, exp_data);
      check({tag, " done req"}, dmem_req, 1'b0);
      check({tag, " done stall"}, MemStall, 1'b0);
      idle_bus();
      tick();
      check({tag, " idle after"}, MemStall, 1'b0);
   endtask

   // Aligned store completing on the first REQ cycle; MemReadData must not move.
   task automatic do_store(input string tag, input logic rd_too, input logic [31:0] addr,
                           input logic [1:0] wb, input logic [31:0] data,
                           input logic [3:0] exp_be, input logic [31:0] exp_wdata,
                           input logic [31:0] exp_rd);
      EXMEMMemRead      = rd_too;
      EXMEMMemWrite     = 1'b1;
      EXMEMMemWrBits    = wb;
      EXMEMALUResult    = addr;
      EXMEMMemWriteData = data;
      tick();
      check({tag, " req"}, dmem_req, 1'b1);
      check({tag, " we"}, dmem_we, 1'b1);
      check({tag, " addr"}, dmem_addr, addr & 32'hFFFF_FFFC);
      check({tag, " be"}, dmem_be, exp_be);
      check({tag, " wdata"}, dmem_wdata, exp_wdata);
      dmem_ready = 1'b1;
      tick();
      check({tag, " done req"}, dmem_req, 1'b0);
      check({tag, " rd held"}, MemReadData, exp_rd);
      idle_bus();
      tick();
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish within 100000 ns");
      $fatal(1, "watchdog");
   end

   initial begin
      rst_n    = 1'b0;
      ExtStall = 1'b0;
      idle_bus();
      #12;
      // Reset state.
      check("rst req", dmem_req, 1'b0);
      check("rst we", dmem_we, 1'b0);
      check("rst be", dmem_be, 4'h0);
      check("rst addr", dmem_addr, 32'h0);
      check("rst wdata", dmem_wdata, 32'h0);
      check("rst rdata", MemReadData, 32'h0);
      check("rst misalign", MemMisalign, 1'b0);
      check("rst buserr", MemBusError, 1'b0);
      check("rst stall", MemStall, 1'b0);
      rst_n = 1'b1;
      tick();

      // lb 0x103, byte 0x80 sign-extended; stall high in IDLE and REQ only.
      do_load("lb", 32'h0000_0103, 3'b011, 32'h80FF_0000, 32'hFFFF_FF80);

      // sh 0x202, ready on the 4th REQ cycle; bus outputs stable throughout.
      EXMEMMemWrite     = 1'b1;
      EXMEMMemWrBits    = 2'b01;
      EXMEMALUResult    = 32'h0000_0202;
      EXMEMMemWriteData = 32'h0000_BEEF;
      #1;
      check("sh idle stall", MemStall, 1'b1);
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("sh req c%0d", i), dmem_req, 1'b1);
         check($sformatf("sh we c%0d", i), dmem_we, 1'b1);
         check($sformatf("sh addr c%0d", i), dmem_addr, 32'h0000_0200);
         check($sformatf("sh be c%0d", i), dmem_be, 4'b1100);
         check($sformatf("sh wdata c%0d", i), dmem_wdata, 32'hBEEF_BEEF);
         check($sformatf("sh stall c%0d", i), MemStall, 1'b1);
         if (i == 3) dmem_ready = 1'b1;
      end
      tick();
      check("sh done req", dmem_req, 1'b0);
      check("sh done stall", MemStall, 1'b0);
      check("sh rd held", MemReadData, 32'hFFFF_FF80);
      idle_bus();
      tick();

      // lw 0x006: misaligned, no bus request, one-cycle flag, result cleared.
      EXMEMMemRead   = 1'b1;
      EXMEMMemRBits  = 3'b000;
      EXMEMALUResult = 32'h0000_0006;
      #1;
      check("mis idle stall", MemStall, 1'b1);
      tick();
      check("mis flag", MemMisalign, 1'b1);
      check("mis req", dmem_req, 1'b0);
      check("mis rdata", MemReadData, 32'h0);
      check("mis done stall", MemStall, 1'b0);
      idle_bus();
      tick();
      check("mis flag clr", MemMisalign, 1'b0);
      check("mis req after", dmem_req, 1'b0);
      check("mis stall after", MemStall, 1'b0);
      check("buserr quiet", MemBusError, 1'b0);

      // lhu 0x002 with ExtStall holding DONE for two cycles.
      EXMEMMemRead   = 1'b1;
      EXMEMMemRBits  = 3'b010;
      EXMEMALUResult = 32'h0000_0002;
      tick();
      check("lhu req", dmem_req, 1'b1);
      dmem_ready = 1'b1;
      dmem_rdata = 32'h9234_5678;
      tick();
      check("lhu data", MemReadData, 32'h0000_9234);
      dmem_ready = 1'b0;
      dmem_rdata = 32'hDEAD_BEEF;
      ExtStall   = 1'b1;
      for (int i = 0; i < 2; i++) begin
         tick();
         check($sformatf("lhu hold data d%0d", i), MemReadData, 32'h0000_9234);
         check($sformatf("lhu hold stall d%0d", i), MemStall, 1'b0);
         check($sformatf("lhu hold req d%0d", i), dmem_req, 1'b0);
      end
      ExtStall = 1'b0;
      idle_bus();
      tick();
      check("lhu back idle req", dmem_req, 1'b0);
      check("lhu back idle stall", MemStall, 1'b0);
      check("lhu data after", MemReadData, 32'h0000_9234);

      // More lanes and extensions.
      do_load("lh", 32'h0000_0040, 3'b001, 32'h1234_8001, 32'hFFFF_8001);
      do_load("lbu", 32'h0000_0041, 3'b100, 32'h0000_F000, 32'h0000_00F0);
      do_load("lw", 32'h0000_0080, 3'b000, 32'hCAFE_F00D, 32'hCAFE_F00D);
      do_store("sb", 1'b0, 32'h0000_00F5, 2'b10, 32'hAABB_CCDD, 4'b0010, 32'hDDDD_DDDD, 32'hCAFE_F00D);
      do_store("rd+wr", 1'b1, 32'h0000_0007, 2'b10, 32'h0000_005A, 4'b1000, 32'h5A5A_5A5A, 32'hCAFE_F00D);
      do_store("sh lo", 1'b0, 32'h0000_0010, 2'b01, 32'h1111_2222, 4'b0011, 32'h2222_2222, 32'hCAFE_F00D);

      // Reset in the middle of REQ drops the request at once; sw re-issues.
      EXMEMMemWrite     = 1'b1;
      EXMEMMemWrBits    = 2'b00;
      EXMEMALUResult    = 32'h0000_0010;
      EXMEMMemWriteData = 32'h1234_5678;
      tick();
      check("rst pre req", dmem_req, 1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      check("rst async req", dmem_req, 1'b0);
      check("rst async be", dmem_be, 4'h0);
      check("rst async addr", dmem_addr, 32'h0);
      check("rst async rdata", MemReadData, 32'h0);
      #1;
      rst_n = 1'b1;
      #1;
      check("rst idle stall", MemStall, 1'b1);
      tick();
      check("reissue req", dmem_req, 1'b1);
      check("reissue we", dmem_we, 1'b1);
      check("reissue be", dmem_be, 4'b1111);
      check("reissue addr", dmem_addr, 32'h0000_0010);
      check("reissue wdata", dmem_wdata, 32'h1234_5678);
      dmem_ready = 1'b1;
      tick();
      check("reissue done req", dmem_req, 1'b0);
      check("reissue done stall", MemStall, 1'b0);
      idle_bus();
      tick();

`ifdef DMEM_TIMEOUT_EN
      // Ready never comes: four REQ cycles, then a bus-error pulse.
      EXMEMMemRead   = 1'b1;
      EXMEMMemRBits  = 3'b000;
      EXMEMALUResult = 32'h0000_0020;
      for (int i = 0; i < 4; i++) begin
         tick();
         check($sformatf("to req c%0d", i), dmem_req, 1'b1);
      end
      tick();
      check("to req drop", dmem_req, 1'b0);
      check("to buserr", MemBusError, 1'b1);
      check("to rdata", MemReadData, 32'h0);
      idle_bus();
      tick();
      check("to buserr clr", MemBusError, 1'b0);
`else
      check("buserr tied", MemBusError, 1'b0);
`endif

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule

// File: doc/mem_access_ctrl.md
Name: mem_access_ctrl

Overview:
- MEM-stage data-memory controller of the pipelined CPU; consumes the EX/MEM pipeline register outputs (address, store data, read/write controls and width codes).
- Runs a request/ready handshake to the data memory, aligns store bytes, and sign/zero-extends load data.
- Drives MemStall back to the EX/MEM register and the earlier pipeline registers, so each access holds the instruction in MEM until it completes.

Parameters:
- TIMEOUT_CYCLES, 255, ready-wait limit in cycles; used only with DMEM_TIMEOUT_EN.

Ports:
- clk  in  1  pipeline clock, rising edge
- rst_n  in  1  asynchronous active-low reset
- EXMEMALUResult  in  32  byte address
- EXMEMMemWriteData  in  32  store data, right-justified
- EXMEMMemRead  in  1  load in MEM
- EXMEMMemRBits  in  3  load type: 000 lw, 001 lh, 010 lhu, 011 lb, 100 lbu (others treated as lw)
- EXMEMMemWrite  in  1  store in MEM
- EXMEMMemWrBits  in  2  store width: 00 word, 01 half, 10 byte (11 treated as word)
- ExtStall  in  1  stall from another source holding EX/MEM
- dmem_req  out  1  bus request
- dmem_we  out  1  bus write enable
- dmem_addr  out  32  word-aligned address, bits [1:0]=00
- dmem_wdata  out  32  lane-replicated write data
- dmem_be  out  4  byte enables
- dmem_rdata  in  32  read data
- dmem_ready  in  1  access-complete strobe
- MemStall  out  1  hold EX/MEM and earlier stages
- MemReadData  out  32  extended load result, registered
- MemMisalign  out  1  one-cycle misaligned-access flag
- MemBusError  out  1  one-cycle timeout flag (tied 0 without the macro)

Behaviour:
- Reset (async, rst_n=0): state IDLE; dmem_req, dmem_we, dmem_be, dmem_addr, dmem_wdata, MemReadData, MemMisalign, MemBusError = 0. An in-flight request is abandoned immediately.
- States: IDLE, REQ, DONE.
- Access pending = EXMEMMemRead | EXMEMMemWrite. If both are set, the access is a store.
- MemStall = pending in IDLE, or state is REQ. MemStall = 0 in DONE.
- IDLE, pending, aligned:
  - Register dmem_addr = {addr[31:2], 2'b00}, dmem_we, dmem_be, dmem_wdata, and the latched addr[1:0] and load type.
  - Next state REQ.
- IDLE, pending, misaligned (half with addr[0]=1, word with addr[1:0]≠0):
  - No bus request; MemMisalign = 1 during the following DONE cycle; MemReadData = 0.
- REQ:
  - dmem_req = 1 and all bus outputs held stable until dmem_ready = 1, including a same-cycle ready.
  - On ready: capture the extended load data into MemReadData, drop dmem_req, go to DONE.
  - Minimum latency: detect (IDLE) → REQ → DONE, i.e. 3 cycles; EX/MEM advances at the end of DONE.
- DONE:
  - If ExtStall = 1, stay in DONE with MemStall = 0 and MemReadData held.
  - Otherwise go to IDLE. The instruction then in EX/MEM is new, so no access is repeated.
- Store lanes:
  - byte: be = 1 << addr[1:0], wdata = byte replicated ×4.
  - half: be = 0011 if addr[1]=0, else 1100; wdata = half replicated ×2.
  - word: be = 1111, wdata unchanged.
  - For loads, dmem_we = 0 and be = 1111.
- Load extraction from rdata:
  - byte lane = addr[1:0], half lane = addr[1].
  - lb/lh sign-extend; lbu/lhu zero-extend.
- MemReadData changes only on REQ→DONE (load) or misalign (cleared to 0); stores leave it unchanged.
- Flags MemMisalign and MemBusError are single-cycle pulses in DONE. They do not repeat while DONE is extended by ExtStall.

Optional Feature:
- DMEM_TIMEOUT_EN defined:
  - An 8+ bit counter clears on entry to REQ and increments each REQ cycle without ready.
  - When the count reaches TIMEOUT_CYCLES: drop dmem_req, MemReadData = 0, MemBusError pulse in DONE.
  - A ready arriving in the same cycle as the limit wins: the access completes normally with no error.
- DMEM_TIMEOUT_EN undefined: no counter; REQ waits indefinitely; MemBusError tied 0.

Test Plan:
- lb, addr 0x103, ready on first REQ cycle, rdata 0x80FF_0000 → dmem_be=1111, MemReadData=0xFFFF_FF80, MemStall high exactly 2 cycles.
- sh, addr 0x202, data 0x0000_BEEF, ready after 3 REQ cycles → dmem_addr=0x200, be=1100, wdata=0xBEEF_BEEF, we=1; outputs stable all 4 REQ cycles.
- lw, addr 0x006 → no dmem_req; MemMisalign pulse 1 cycle; MemStall 1 cycle; MemReadData=0.
- lhu, addr 0x002, rdata 0x9234_5678, ExtStall=1 for 2 cycles in DONE → MemReadData=0x0000_9234 held; single access only; return to IDLE after ExtStall drops.
- rst_n low during REQ → dmem_req falls immediately (async), state IDLE; after release, a pending sw re-issues from IDLE.
- DMEM_TIMEOUT_EN, TIMEOUT_CYCLES=4, ready never asserted → dmem_req drops after 4 REQ cycles; MemBusError 1-cycle pulse; MemReadData=0.
